// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-select
// patterns, wait-state limits and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SEL_WORD = 4'b1111;
    localparam logic [3:0] SEL_HI   = 4'b1100;
    localparam logic [3:0] SEL_LO   = 4'b0011;
    localparam logic [3:0] SEL_NONE = 4'b0000;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Request fields captured in IDLE; the word index is kept separately since
    // its width follows ADDR_W.
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [1:0]  off;
        logic [31:0] dat;
    } dmem_req_t;

    function automatic logic dmem_misaligned(input logic [3:0] sel, input logic [1:0] off);
        return ((sel == SEL_WORD) && (off != 2'b00)) ||
               (((sel == SEL_HI) || (sel == SEL_LO)) && off[0]) ||
               (sel == SEL_NONE);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-indexed RAM built from four byte lanes; lane 3 holds bits [31:24].
// Latency: write on rising edge, combinational word read; no backpressure.
// Backpressure: none, caller sequences accesses. Contents are not reset.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_dat,
    output logic [31:0]       rd_dat
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [0:(1<<ADDR_W)-1];

        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[addr] <= wr_dat[8*l +: 8];
            end
        end

        assign rd_dat[8*l +: 8] = mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, WAIT_CYCLES
// busy cycles then a DONE cycle; stalls the pipeline until DONE. Alignment
// checking and write suppression are built only with DMEM_MISALIGN_CHK_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        misalign_o
);

    if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $error("data_mem_responder: WAIT_CYCLES out of range 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    dmem_req_t         req;
    logic [ADDR_W-1:0] req_idx;
    logic              mis_q;
    logic              access;
    logic              flag;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rd;

    // The access fires on the last BUSY edge, unless the MEM stage flushed.
    assign access = (state == ST_BUSY) && mem_ce_i && (cnt == 4'd0);

`ifdef DMEM_MISALIGN_CHK_EN
    assign flag       = dmem_misaligned(req.sel, req.off);
    assign misalign_o = mis_q;
`else
    assign flag       = 1'b0;
    assign misalign_o = 1'b0;
    logic unused_chk;
    assign unused_chk = ^{req.off, mis_q};
`endif

    logic unused_addr;
    assign unused_addr = ^mem_addr_i[31:ADDR_W+2];

    assign ram_we     = (access && req.we && !flag) ? req.sel : SEL_NONE;
    assign stallreq_o = mem_ce_i && (state != ST_DONE);

    dmem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .addr   (req_idx),
        .wr_dat (req.dat),
        .rd_dat (ram_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req        <= '0;
            req_idx    <= '0;
            mem_data_o <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_ce_i) begin
                        req     <= '{we: mem_we_i, sel: mem_sel_i,
                                     off: mem_addr_i[1:0], dat: mem_data_i};
                        req_idx <= mem_addr_i[ADDR_W+1:2];
                        cnt     <= CNT_LOAD;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!mem_ce_i) begin
                        state <= ST_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!req.we) begin
                            mem_data_o <= ram_rd;
                        end
                        mis_q <= flag;
                        state <= ST_DONE;
                    end
                end
                // Pipeline advances at the end of DONE; the held request is not reissued.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
